// File: rtl/maj_fold_sequencer.sv
// Folded majority evaluator: counts one CHUNK of the captured vote vector per
// cycle and reports (popcount >= THRESH), optionally stopping once the outcome
// can no longer change.
module maj_fold_sequencer #(
  parameter int unsigned N          = 37,
  parameter int unsigned CHUNK      = 8,
  parameter int unsigned THRESH     = (N + 1) / 2,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [N-1:0]                                in_vec,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_maj,
  output logic [$clog2(N+1)-1:0]                      out_count,
  output logic [$clog2((N+CHUNK-1)/CHUNK+1)-1:0]      out_chunks
);

  localparam int unsigned K  = (N + CHUNK - 1) / CHUNK;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned KW = $clog2(K + 1);
  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = K * CHUNK;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   vec_q, vec_n;
  logic [CW-1:0]  acc, acc_nx;
  logic [IW-1:0]  idx, idx_nx;
  logic           maj_n;
  logic [CW-1:0]  cnt_n;
  logic [KW-1:0]  chk_n;

  logic [PW-1:0]    vec_pad;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    pc;
  logic [CW-1:0]    acc_sum;
  int unsigned      consumed;
  logic             last;
  logic             decided;

  // Current chunk popcount, running sum and early-decision test
  always_comb begin
    vec_pad          = '0;
    vec_pad[N-1:0]   = vec_q;
    chunk            = vec_pad[32'(idx) * CHUNK +: CHUNK];
    pc               = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      pc = pc + CW'(chunk[i]);
    end
    acc_sum  = acc + pc;
    consumed = (32'(idx) + 32'd1) * CHUNK;
    if (consumed > N) begin
      consumed = N;
    end
    last    = (idx == IW'(K - 1));
    decided = (32'(acc_sum) >= THRESH) || ((32'(acc_sum) + (N - consumed)) < THRESH);
  end

  // Next-state and next-register logic
  always_comb begin
    state_n = state;
    vec_n   = vec_q;
    acc_nx  = acc;
    idx_nx  = idx;
    maj_n   = out_maj;
    cnt_n   = out_count;
    chk_n   = out_chunks;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          vec_n   = in_vec;
          acc_nx  = '0;
          idx_nx  = '0;
          state_n = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (last || (EARLY_EXIT && decided)) begin
          maj_n   = (32'(acc_sum) >= THRESH);
          cnt_n   = acc_sum;
          chk_n   = KW'(32'(idx) + 32'd1);
          state_n = S_DONE;
        end else begin
          acc_nx = acc_sum;
          idx_nx = idx + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec_q      <= '0;
      acc        <= '0;
      idx        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_maj    <= 1'b0;
      out_count  <= '0;
      out_chunks <= '0;
    end else begin
      state      <= state_n;
      vec_q      <= vec_n;
      acc        <= acc_nx;
      idx        <= idx_nx;
      in_ready   <= (state_n == S_IDLE);
      out_valid  <= (state_n == S_DONE);
      out_maj    <= maj_n;
      out_count  <= cnt_n;
      out_chunks <= chk_n;
    end
  end

endmodule
